// File: rtl/mkmif_arbiter.sv
// Round-robin arbiter sharing one mkmif_core between two 32-bit word requesters.
// Sequences the core's one-cycle op handshake, holds operands, and times out stalled ops.
module mkmif_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [31:0] a_rdata,

  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [31:0] b_rdata,

  output logic        core_read_op,
  output logic        core_write_op,
  output logic [15:0] core_addr,
  output logic [31:0] core_write_data,
  input  logic        core_ready,
  input  logic [31:0] core_read_data,

  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GAP   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  state_e      state_q;
  logic        owner_b_q;
  logic        last_grant_b_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] timer_q;
  logic        core_read_op_q;
  logic        core_write_op_q;
  logic        a_ack_q;
  logic        a_err_q;
  logic        b_ack_q;
  logic        b_err_q;
  logic [31:0] a_rdata_q;
  logic [31:0] b_rdata_q;

  logic        grant_valid_d;
  logic        grant_b_d;
  logic        grant_we_d;
  logic [15:0] grant_addr_d;
  logic [31:0] grant_wdata_d;
  logic [16:0] timer_inc_s;
  logic        expire_s;

  // Round-robin pick: on contention the port that did not win last time is served.
  always_comb begin
    grant_valid_d = 1'b0;
    grant_b_d     = 1'b0;
    if (a_req && b_req) begin
      grant_valid_d = 1'b1;
      grant_b_d     = ~last_grant_b_q;
    end else if (a_req) begin
      grant_valid_d = 1'b1;
      grant_b_d     = 1'b0;
    end else if (b_req) begin
      grant_valid_d = 1'b1;
      grant_b_d     = 1'b1;
    end else begin
      grant_valid_d = 1'b0;
      grant_b_d     = 1'b0;
    end
  end

  assign grant_we_d    = grant_b_d ? b_we    : a_we;
  assign grant_addr_d  = grant_b_d ? b_addr  : a_addr;
  assign grant_wdata_d = grant_b_d ? b_wdata : a_wdata;

  // 17-bit increment so the expiry compare cannot wrap even at the largest timeout.
  assign timer_inc_s = {1'b0, timer_q} + 17'd1;
  assign expire_s    = (timer_inc_s == {1'b0, TIMEOUT_CYCLES});

  // Arbitration/sequencing FSM with all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      owner_b_q       <= 1'b0;
      last_grant_b_q  <= 1'b1;
      we_q            <= 1'b0;
      addr_q          <= 16'h0000;
      wdata_q         <= 32'h0000_0000;
      timer_q         <= 16'h0000;
      core_read_op_q  <= 1'b0;
      core_write_op_q <= 1'b0;
      a_ack_q         <= 1'b0;
      a_err_q         <= 1'b0;
      b_ack_q         <= 1'b0;
      b_err_q         <= 1'b0;
      a_rdata_q       <= 32'h0000_0000;
      b_rdata_q       <= 32'h0000_0000;
    end else begin
      core_read_op_q  <= 1'b0;
      core_write_op_q <= 1'b0;
      a_ack_q         <= 1'b0;
      a_err_q         <= 1'b0;
      b_ack_q         <= 1'b0;
      b_err_q         <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The core is only offered work while it reports ready (init done, not stuck).
          if (core_ready && grant_valid_d) begin
            owner_b_q       <= grant_b_d;
            last_grant_b_q  <= grant_b_d;
            we_q            <= grant_we_d;
            addr_q          <= grant_addr_d;
            wdata_q         <= grant_wdata_d;
            core_write_op_q <= grant_we_d;
            core_read_op_q  <= ~grant_we_d;
            state_q         <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          timer_q <= 16'h0000;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_ready) begin
            if (!we_q) begin
              if (owner_b_q) begin
                b_rdata_q <= core_read_data;
              end else begin
                a_rdata_q <= core_read_data;
              end
            end else begin
              a_rdata_q <= a_rdata_q;
            end
            a_ack_q <= ~owner_b_q;
            b_ack_q <= owner_b_q;
            state_q <= ST_RESP;
          end else if (expire_s) begin
            a_ack_q <= ~owner_b_q;
            b_ack_q <= owner_b_q;
            a_err_q <= ~owner_b_q;
            b_err_q <= owner_b_q;
            state_q <= ST_RESP;
          end else begin
            timer_q <= timer_inc_s[15:0];
            state_q <= ST_WAIT;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign core_read_op    = core_read_op_q;
  assign core_write_op   = core_write_op_q;
  assign core_addr       = addr_q;
  assign core_write_data = wdata_q;
  assign a_ack           = a_ack_q;
  assign a_err           = a_err_q;
  assign a_rdata         = a_rdata_q;
  assign b_ack           = b_ack_q;
  assign b_err           = b_err_q;
  assign b_rdata         = b_rdata_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mkmif_arbiter.sv
// Directed bench for mkmif_arbiter with a small behavioural mkmif_core model
// (ready drops after each op, returns after a programmable delay or not at all).
module tb_mkmif_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        core_read_op, core_write_op;
  logic [15:0] core_addr;
  logic [31:0] core_write_data;
  logic        core_ready = 1'b0;
  logic [31:0] core_read_data = 32'h0000_0000;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] mem [0:255];
  int          model_delay = 1;
  bit          model_hold  = 1'b1;
  bit          pend        = 1'b0;
  int          cnt         = 0;
  logic        op_we       = 1'b0;
  logic [15:0] op_addr     = 16'h0000;
  logic [31:0] op_wd       = 32'h0000_0000;

  mkmif_arbiter #(.TIMEOUT_CYCLES(16'd1000)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .core_read_op(core_read_op), .core_write_op(core_write_op),
    .core_addr(core_addr), .core_write_data(core_write_data),
    .core_ready(core_ready), .core_read_data(core_read_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model: updates on the falling edge so the DUT samples stable values.
  always @(negedge clk) begin
    if (!reset_n) begin
      core_ready = 1'b0;
      pend = 1'b0;
      cnt = 0;
    end else if (core_read_op || core_write_op) begin
      pend = 1'b1;
      op_we = core_write_op;
      op_addr = core_addr;
      op_wd = core_write_data;
    end else if (pend) begin
      pend = 1'b0;
      core_ready = 1'b0;
      cnt = model_delay;
    end else if (!core_ready && !model_hold) begin
      if (cnt > 1) begin
        cnt = cnt - 1;
      end else begin
        core_ready = 1'b1;
        if (op_we) mem[op_addr[7:0]] = op_wd;
        else core_read_data = mem[op_addr[7:0]];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_op(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (core_read_op || core_write_op) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (a_ack || b_ack) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, core_read_op, core_write_op, a_ack, b_ack, a_err, b_err} !== 7'b0) begin
      n_mis++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {busy, core_read_op, core_write_op, a_ack, b_ack, a_err, b_err});
    end
    n_cmp++;
    if ({core_addr, core_write_data, a_rdata, b_rdata} !== 112'd0) begin
      n_mis++;
      $display("FAIL reset_data: got %h %h %h %h expected all 0", core_addr, core_write_data, a_rdata, b_rdata);
    end
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_startup();
    int viol = 0;
    int n;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0005;
    for (int i = 0; i < 50; i++) begin
      step();
      if (core_read_op || core_write_op || busy) viol++;
    end
    n_cmp++;
    if (viol !== 0) begin
      n_mis++;
      $display("FAIL startup_hold: got %0d active cycles expected 0", viol);
    end
    model_hold = 1'b0;
    model_delay = 1;
    wait_op(10, n);
    n_cmp++;
    if (n < 0 || core_read_op !== 1'b1 || core_addr !== 16'h0005) begin
      n_mis++;
      $display("FAIL startup_op: got n=%0d rd=%b addr=%h expected rd=1 addr=0005", n, core_read_op, core_addr);
    end
    step();
    n_cmp++;
    if (core_read_op !== 1'b0) begin
      n_mis++;
      $display("FAIL startup_pulse: got %b expected 0", core_read_op);
    end
    wait_ack(10, n);
    a_req = 1'b0;
    n_cmp++;
    if (n < 0 || a_ack !== 1'b1 || a_err !== 1'b0 || a_rdata !== 32'h1234_5678) begin
      n_mis++;
      $display("FAIL startup_ack: got ack=%b err=%b rdata=%h expected 1 0 12345678", a_ack, a_err, a_rdata);
    end
  endtask

  task automatic test_write();
    int wr = 0, rd = 0, unstable = 0, acks = 0, backs = 0, op_at = -1, ack_at = -1;
    logic err_seen = 1'b1;
    step();
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0010; a_wdata = 32'hDEAD_BEEF;
    model_delay = 20;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (core_write_op) begin wr++; op_at = i; end
      if (core_read_op) rd++;
      if (busy && (core_addr !== 16'h0010 || core_write_data !== 32'hDEAD_BEEF)) unstable++;
      if (b_ack) backs++;
      if (a_ack) begin acks++; ack_at = i; err_seen = a_err; a_req = 1'b0; end
    end
    n_cmp++;
    if (wr !== 1 || rd !== 0) begin
      n_mis++;
      $display("FAIL write_ops: got wr=%0d rd=%0d expected 1 0", wr, rd);
    end
    n_cmp++;
    if (unstable !== 0) begin
      n_mis++;
      $display("FAIL write_stable: got %0d unstable cycles expected 0", unstable);
    end
    n_cmp++;
    if (acks !== 1 || backs !== 0 || err_seen !== 1'b0) begin
      n_mis++;
      $display("FAIL write_ack: got a_ack=%0d b_ack=%0d err=%b expected 1 0 0", acks, backs, err_seen);
    end
    n_cmp++;
    if (ack_at - op_at !== 22) begin
      n_mis++;
      $display("FAIL write_latency: got %0d expected 22", ack_at - op_at);
    end
  endtask

  task automatic test_read();
    int op_at = -1, ack_at = -1;
    logic [31:0] pre = 32'h0, at_ack = 32'h0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
    model_delay = 3;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (core_read_op) begin op_at = i; pre = a_rdata; end
      if (a_ack) begin ack_at = i; at_ack = a_rdata; a_req = 1'b0; end
    end
    n_cmp++;
    if (pre !== 32'h1234_5678) begin
      n_mis++;
      $display("FAIL read_pre: got %h expected 12345678", pre);
    end
    n_cmp++;
    if (at_ack !== 32'hDEAD_BEEF || a_rdata !== 32'hDEAD_BEEF) begin
      n_mis++;
      $display("FAIL read_data: got %h/%h expected deadbeef", at_ack, a_rdata);
    end
    n_cmp++;
    if (ack_at - op_at !== 5) begin
      n_mis++;
      $display("FAIL read_latency: got %0d expected 5", ack_at - op_at);
    end
    n_cmp++;
    if (b_rdata !== 32'h0) begin
      n_mis++;
      $display("FAIL read_b_rdata: got %h expected 0", b_rdata);
    end
  endtask

  task automatic test_b_single();
    int n;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0010;
    model_delay = 2;
    wait_ack(20, n);
    b_req = 1'b0;
    n_cmp++;
    if (n < 0 || b_ack !== 1'b1 || a_ack !== 1'b0 || b_rdata !== 32'hDEAD_BEEF) begin
      n_mis++;
      $display("FAIL b_read: got b_ack=%b a_ack=%b b_rdata=%h expected 1 0 deadbeef", b_ack, a_ack, b_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    string ord = "";
    logic [16:0] ops [4];
    logic [16:0] exp_ops [4];
    int nop = 0, na = 0, nb = 0, errs = 0;
    logic [31:0] a_rd2 = 32'h0, b_rd2 = 32'h0;
    exp_ops[0] = {1'b1, 16'h0020};
    exp_ops[1] = {1'b1, 16'h0030};
    exp_ops[2] = {1'b0, 16'h0030};
    exp_ops[3] = {1'b0, 16'h0020};
    for (int i = 0; i < 4; i++) ops[i] = 17'h0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0020; a_wdata = 32'hA000_0001;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0030; b_wdata = 32'hB000_0001;
    model_delay = 2;
    for (int i = 0; i < 100; i++) begin
      step();
      if (core_read_op || core_write_op) begin
        if (nop < 4) ops[nop] = {core_write_op, core_addr};
        nop++;
      end
      if (a_ack) begin
        ord = {ord, "A"}; na++;
        if (a_err) errs++;
        if (na == 1) begin a_we = 1'b0; a_addr = 16'h0030; end
        else begin a_req = 1'b0; a_rd2 = a_rdata; end
      end
      if (b_ack) begin
        ord = {ord, "B"}; nb++;
        if (b_err) errs++;
        if (nb == 1) begin b_we = 1'b0; b_addr = 16'h0020; end
        else begin b_req = 1'b0; b_rd2 = b_rdata; end
      end
      if (na >= 2 && nb >= 2) break;
    end
    n_cmp++;
    if (ord != "ABAB") begin
      n_mis++;
      $display("FAIL rr_order: got %s expected ABAB", ord);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ops[i] !== exp_ops[i]) begin
        n_mis++;
        $display("FAIL rr_op%0d: got we/addr %h expected %h", i, ops[i], exp_ops[i]);
      end
    end
    n_cmp++;
    if (a_rd2 !== 32'hB000_0001 || b_rd2 !== 32'hA000_0001 || errs !== 0) begin
      n_mis++;
      $display("FAIL rr_data: got a=%h b=%h errs=%0d expected b0000001 a0000001 0", a_rd2, b_rd2, errs);
    end
    step();
  endtask

  task automatic test_timeout();
    int op_at = -1, ack_at = -1, viol = 0, n, backs = 0;
    logic err_seen = 1'b0;
    logic [31:0] rd_seen = 32'h0;
    model_hold = 1'b1;
    model_delay = 1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0020;
    for (int i = 1; i <= 1100; i++) begin
      step();
      if (core_read_op) op_at = i;
      if (b_ack) backs++;
      if (a_ack) begin ack_at = i; err_seen = a_err; rd_seen = a_rdata; break; end
    end
    n_cmp++;
    if (ack_at < 0 || ack_at - op_at !== 1002) begin
      n_mis++;
      $display("FAIL timeout_latency: got %0d expected 1002", ack_at - op_at);
    end
    n_cmp++;
    if (err_seen !== 1'b1 || rd_seen !== 32'hB000_0001 || backs !== 0) begin
      n_mis++;
      $display("FAIL timeout_resp: got err=%b rdata=%h b_ack=%0d expected 1 b0000001 0", err_seen, rd_seen, backs);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (core_read_op || core_write_op || busy) viol++;
    end
    n_cmp++;
    if (viol !== 0) begin
      n_mis++;
      $display("FAIL timeout_hold: got %0d active cycles expected 0", viol);
    end
    model_hold = 1'b0;
    wait_op(10, n);
    n_cmp++;
    if (n < 0 || core_addr !== 16'h0020) begin
      n_mis++;
      $display("FAIL timeout_retry_op: got n=%0d addr=%h expected addr 0020", n, core_addr);
    end
    wait_ack(10, n);
    a_req = 1'b0;
    n_cmp++;
    if (n < 0 || a_err !== 1'b0 || a_rdata !== 32'hA000_0001) begin
      n_mis++;
      $display("FAIL timeout_retry_ack: got err=%b rdata=%h expected 0 a0000001", a_err, a_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0030;
    model_delay = 100;
    wait_op(10, n);
    repeat (5) step();
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, core_read_op, core_write_op, a_ack, b_ack, a_err, b_err} !== 7'b0 ||
        {core_addr, core_write_data, a_rdata, b_rdata} !== 112'd0) begin
      n_mis++;
      $display("FAIL midreset_outputs: got busy=%b addr=%h a_rdata=%h b_rdata=%h expected all 0",
               busy, core_addr, a_rdata, b_rdata);
    end
    model_delay = 1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0010;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_op(10, n);
    n_cmp++;
    if (n < 0 || core_addr !== 16'h0030) begin
      n_mis++;
      $display("FAIL midreset_priority: got n=%0d addr=%h expected addr 0030", n, core_addr);
    end
    wait_ack(10, n);
    a_req = 1'b0;
    n_cmp++;
    if (n < 0 || a_ack !== 1'b1 || b_ack !== 1'b0 || a_rdata !== 32'hB000_0001) begin
      n_mis++;
      $display("FAIL midreset_a: got a_ack=%b b_ack=%b rdata=%h expected 1 0 b0000001", a_ack, b_ack, a_rdata);
    end
    wait_ack(10, n);
    b_req = 1'b0;
    n_cmp++;
    if (n < 0 || b_ack !== 1'b1 || b_rdata !== 32'hDEAD_BEEF) begin
      n_mis++;
      $display("FAIL midreset_b: got b_ack=%b rdata=%h expected 1 deadbeef", b_ack, b_rdata);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[5] = 32'h1234_5678;
    a_req = 1'b0; a_we = 1'b0; a_addr = 16'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 16'h0; b_wdata = 32'h0;
    test_reset();
    test_startup();
    test_write();
    test_read();
    test_b_single();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
